// File: rtl/hist_pixel_packer.sv
// hist_pixel_packer: packs the 8-bit equalised pixel stream into PixelsPerWord-wide
// AXI4-Stream beats for the DMA S2MM port, buffered by a first-word-fall-through FIFO.
// Optional frame-length check enabled by defining HIST_PACKER_FRAME_CHECK_EN.
module hist_pixel_packer #(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned PixelsPerWord = 4,
  parameter int unsigned FifoDepth     = 16,
  parameter int unsigned imageSize     = 640*480
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic [DataWidth-1:0]               i_pixel,
  input  logic                               i_pixel_valid,
  input  logic                               i_pixel_last,
  output logic                               o_pixel_ready,
  output logic [DataWidth*PixelsPerWord-1:0] m_axis_tdata,
  output logic [PixelsPerWord-1:0]           m_axis_tkeep,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready,
  output logic                               o_overflow,
  output logic                               o_frame_err
);

  localparam int unsigned WordW = DataWidth * PixelsPerWord;
  localparam int unsigned LaneW = $clog2(PixelsPerWord);
  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = $clog2(FifoDepth + 1);
  localparam int unsigned EntW  = WordW + PixelsPerWord + 1;

  logic [LaneW-1:0]         lane_q, lane_d;
  logic [WordW-1:0]         hold_q, hold_d;
  logic [WordW-1:0]         word;
  logic [PixelsPerWord-1:0] keep;
  logic                     accept, push, pop;

  logic [EntW-1:0]          mem_q [FifoDepth];
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]          count_q, count_d;
  logic                     overflow_q;

  assign o_pixel_ready = (count_q < CntW'(FifoDepth));
  assign accept        = i_pixel_valid & o_pixel_ready;
  assign push          = accept & ((lane_q == LaneW'(PixelsPerWord - 1)) | i_pixel_last);
  assign m_axis_tvalid = (count_q != '0);
  assign pop           = m_axis_tvalid & m_axis_tready;

  // Outputs read zero while the FIFO is empty so the beat fields come out of reset at 0
  // without resetting the storage array; while valid, the head entry cannot be overwritten.
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
  assign o_overflow = overflow_q;

  // Merge the incoming pixel into the held lanes and derive the lane keep mask.
  always_comb begin
    word = hold_q;
    word[lane_q*DataWidth +: DataWidth] = i_pixel;
    keep = '0;
    for (int unsigned i = 0; i < PixelsPerWord; i++) begin
      keep[i] = (i <= 32'(lane_q));
    end
  end

  // Lane counter / hold register next state.
  always_comb begin
    hold_d = hold_q;
    lane_d = lane_q;
    if (accept) begin
      if (push) begin
        hold_d = '0;
        lane_d = '0;
      end else begin
        hold_d = word;
        lane_d = lane_q + 1'b1;
      end
    end
  end

  // FIFO occupancy next state; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Packer state, FIFO pointers, count and sticky overflow.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lane_q     <= '0;
      hold_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (i_pixel_valid && !o_pixel_ready) overflow_q <= 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_pixel_last, keep, word};
  end

`ifdef HIST_PACKER_FRAME_CHECK_EN
  localparam int unsigned PixW = $clog2(imageSize + 1);

  logic [PixW-1:0] pix_cnt_q, pix_cnt_d, pix_inc;
  logic            frame_err_q, frame_err_d;

  assign pix_inc     = pix_cnt_q + 1'b1;
  assign o_frame_err = frame_err_q;

  // Frame length check on accepted pixels; counter restarts after every last.
  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    frame_err_d = frame_err_q;
    if (accept) begin
      if (i_pixel_last) begin
        pix_cnt_d = '0;
        if (pix_inc != PixW'(imageSize)) frame_err_d = 1'b1;
      end else begin
        pix_cnt_d = pix_inc;
        if (pix_inc == PixW'(imageSize)) frame_err_d = 1'b1;
      end
    end
  end

  // Frame check registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pix_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end
`else
  assign o_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_hist_pixel_packer.sv
// Directed self-checking bench for hist_pixel_packer (PPW=4, FifoDepth=4, imageSize=8).
module tb_hist_pixel_packer;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [7:0]  i_pixel;
  logic        i_pixel_valid;
  logic        i_pixel_last;
  logic        o_pixel_ready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        o_overflow;
  logic        o_frame_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        exp_ferr;

  hist_pixel_packer #(
    .DataWidth    (8),
    .PixelsPerWord(4),
    .FifoDepth    (4),
    .imageSize    (8)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_pixel      (i_pixel),
    .i_pixel_valid(i_pixel_valid),
    .i_pixel_last (i_pixel_last),
    .o_pixel_ready(o_pixel_ready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .o_overflow   (o_overflow),
    .o_frame_err  (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one pixel for a single cycle; returns #1 after the sampling edge.
  task automatic send_px(input logic [7:0] px, input logic last);
    i_pixel       = px;
    i_pixel_valid = 1'b1;
    i_pixel_last  = last;
    tick();
    i_pixel_valid = 1'b0;
    i_pixel_last  = 1'b0;
  endtask

  // Check the head beat, then pop it.
  task automatic pop_chk(input string tag, input logic [31:0] d, input logic [3:0] k,
                         input logic l);
    chk({tag, ".valid"}, 64'(m_axis_tvalid), 64'(1'b1));
    chk({tag, ".data"},  64'(m_axis_tdata),  64'(d));
    chk({tag, ".keep"},  64'(m_axis_tkeep),  64'(k));
    chk({tag, ".last"},  64'(m_axis_tlast),  64'(l));
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
  endtask

  task automatic reset_pulse();
    i_reset_n = 1'b0;
    #3;
    chk("rst.valid", 64'(m_axis_tvalid), 64'(1'b0));
    chk("rst.ready", 64'(o_pixel_ready), 64'(1'b1));
    chk("rst.ovf",   64'(o_overflow),    64'(1'b0));
    chk("rst.ferr",  64'(o_frame_err),   64'(1'b0));
    i_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    i_reset_n     = 1'b0;
    i_pixel       = '0;
    i_pixel_valid = 1'b0;
    i_pixel_last  = 1'b0;
    m_axis_tready = 1'b0;

    // 1: reset state
    tick();
    tick();
    chk("t1.valid", 64'(m_axis_tvalid), 64'(1'b0));
    chk("t1.last",  64'(m_axis_tlast),  64'(1'b0));
    chk("t1.data",  64'(m_axis_tdata),  64'(0));
    chk("t1.keep",  64'(m_axis_tkeep),  64'(0));
    chk("t1.ovf",   64'(o_overflow),    64'(1'b0));
    chk("t1.ready", 64'(o_pixel_ready), 64'(1'b1));
    i_reset_n = 1'b1;
    tick();
    chk("t1.valid_post", 64'(m_axis_tvalid), 64'(1'b0));

    // 2: one full word with tready high, beat visible one cycle after the 4th pixel
    m_axis_tready = 1'b1;
    send_px(8'h11, 1'b0);
    send_px(8'h22, 1'b0);
    send_px(8'h33, 1'b0);
    chk("t2.valid_early", 64'(m_axis_tvalid), 64'(1'b0));
    send_px(8'h44, 1'b0);
    pop_chk("t2", 32'h44332211, 4'hF, 1'b0);
    chk("t2.empty", 64'(m_axis_tvalid), 64'(1'b0));

    // 3: last terminates a partial word
    for (int i = 1; i <= 6; i++) send_px(8'(i), (i == 6));
    pop_chk("t3a", 32'h04030201, 4'hF, 1'b0);
    pop_chk("t3b", 32'h00000605, 4'h3, 1'b1);
    chk("t3.empty", 64'(m_axis_tvalid), 64'(1'b0));

    // 4: fill FIFO, overflow on 17th pixel, then drain
    for (int i = 1; i <= 16; i++) send_px(8'(i), 1'b0);
    chk("t4.ready_full", 64'(o_pixel_ready), 64'(1'b0));
    chk("t4.ovf_pre",    64'(o_overflow),    64'(1'b0));
    send_px(8'h99, 1'b0);
    chk("t4.ovf",        64'(o_overflow),    64'(1'b1));
    pop_chk("t4a", 32'h04030201, 4'hF, 1'b0);
    chk("t4.ready_free", 64'(o_pixel_ready), 64'(1'b1));
    pop_chk("t4b", 32'h08070605, 4'hF, 1'b0);
    pop_chk("t4c", 32'h0C0B0A09, 4'hF, 1'b0);
    pop_chk("t4d", 32'h100F0E0D, 4'hF, 1'b0);
    chk("t4.empty", 64'(m_axis_tvalid), 64'(1'b0));
    chk("t4.ready", 64'(o_pixel_ready), 64'(1'b1));
    chk("t4.ovf_sticky", 64'(o_overflow), 64'(1'b1));

    // 5: reset mid-word discards held lanes
    send_px(8'h55, 1'b0);
    send_px(8'h66, 1'b0);
    reset_pulse();
    send_px(8'hAA, 1'b0);
    send_px(8'hBB, 1'b0);
    send_px(8'hCC, 1'b0);
    send_px(8'hDD, 1'b0);
    pop_chk("t5", 32'hDDCCBBAA, 4'hF, 1'b0);
    chk("t5.empty", 64'(m_axis_tvalid), 64'(1'b0));

    // 6: short frame (last on 6th of 8)
`ifdef HIST_PACKER_FRAME_CHECK_EN
    exp_ferr = 1'b1;
`else
    exp_ferr = 1'b0;
`endif
    reset_pulse();
    for (int i = 1; i <= 5; i++) send_px(8'(i), 1'b0);
    chk("t6.ferr_pre", 64'(o_frame_err), 64'(1'b0));
    send_px(8'h06, 1'b1);
    chk("t6.ferr", 64'(o_frame_err), 64'(exp_ferr));
    pop_chk("t6a", 32'h04030201, 4'hF, 1'b0);
    pop_chk("t6b", 32'h00000605, 4'h3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
